// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the bit-serial ALU controller: opcode constants,
// FSM state encodings and small opcode helpers. Other ALU/mux blocks reuse
// the opcode constants from here.
package alu_ctrl_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // True for opcodes that produce meaningful carry/overflow flags.
    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // Carry flop preset at accept: SUB is a + ~b + 1, everything else starts at 0.
    function automatic logic carry_preset(input logic [2:0] op);
        return (op == OP_SUB) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/alu_slice_1b.sv
// One-bit ALU slice used serially by bit_serial_alu_ctrl. Purely
// combinational; SUB inverts b here so the carry chain is a plain adder.
// Reserved opcodes produce r=0 and cout=0.
module alu_slice_1b
    import alu_ctrl_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [2:0] op,
    output logic       r,
    output logic       cout
);

    logic b_eff;

    // Bit-level function select with full-adder path for ADD/SUB.
    always_comb begin
        b_eff = b;
        r     = 1'b0;
        cout  = 1'b0;
        case (op)
            OP_AND: begin
                r    = a & b;
                cout = 1'b0;
            end
            OP_OR: begin
                r    = a | b;
                cout = 1'b0;
            end
            OP_XOR: begin
                r    = a ^ b;
                cout = 1'b0;
            end
            OP_ADD: begin
                r    = a ^ b ^ cin;
                cout = (a & b) | (a & cin) | (b & cin);
            end
            OP_SUB: begin
                b_eff = ~b;
                r     = a ^ b_eff ^ cin;
                cout  = (a & b_eff) | (a & cin) | (b_eff & cin);
            end
            default: begin
                r    = 1'b0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial ALU controller: accepts an operation in IDLE, processes one
// bit per cycle LSB-first through a single alu_slice_1b for WIDTH cycles,
// then pulses done for one cycle with result and flags.
// Optional feature: define ALU_CTRL_ABORT_EN to add an abort input that
// cancels an operation in RUN without touching result or flags.
module bit_serial_alu_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef ALU_CTRL_ABORT_EN
    input  logic             abort,
`endif
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_r;
    state_t           state_s;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] result_r;
    logic             cout_r;
    logic             ovf_r;
    logic             zero_r;

    logic             abort_s;
    logic             accept_s;
    logic             last_s;
    logic             slice_r_s;
    logic             slice_cout_s;
    logic [WIDTH-1:0] final_s;
    logic             ready_s;
    logic             done_s;

`ifdef ALU_CTRL_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    assign accept_s = start && (state_r == ST_IDLE);
    assign last_s   = (state_r == ST_RUN) && (cnt_r == LAST_BIT);

    alu_slice_1b u_slice (
        .a    (a_r[cnt_r]),
        .b    (b_r[cnt_r]),
        .cin  (carry_r),
        .op   (op_r),
        .r    (slice_r_s),
        .cout (slice_cout_s)
    );

    // Full result as it will be on the final RUN cycle: earlier bits plus the MSB from the slice.
    always_comb begin
        final_s            = acc_r;
        final_s[WIDTH-1]   = slice_r_s;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; abort only matters in RUN.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort_s) begin
                    state_s = ST_IDLE;
                end else if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM output decode straight from the state register.
    always_comb begin
        ready_s = (state_r == ST_IDLE);
        done_s  = (state_r == ST_DONE);
    end

    // Operand capture at accept and per-bit serial processing in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            op_r    <= 3'b000;
            cnt_r   <= '0;
            carry_r <= 1'b0;
            acc_r   <= '0;
        end else if (accept_s) begin
            a_r     <= a;
            b_r     <= b;
            op_r    <= op;
            cnt_r   <= '0;
            carry_r <= carry_preset(op);
        end else if ((state_r == ST_RUN) && !abort_s) begin
            acc_r[cnt_r] <= slice_r_s;
            carry_r      <= slice_cout_s;
            cnt_r        <= cnt_r + CW'(1);
        end else begin
            cnt_r   <= cnt_r;
            carry_r <= carry_r;
        end
    end

    // Result and flags update only at the RUN->DONE edge so partial results never show.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r <= '0;
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
            zero_r   <= 1'b0;
        end else if (last_s && !abort_s) begin
            result_r <= final_s;
            cout_r   <= is_arith(op_r) ? slice_cout_s : 1'b0;
            ovf_r    <= is_arith(op_r) ? (carry_r ^ slice_cout_s) : 1'b0;
            zero_r   <= (final_s == '0);
        end else begin
            result_r <= result_r;
            cout_r   <= cout_r;
            ovf_r    <= ovf_r;
            zero_r   <= zero_r;
        end
    end

    assign ready  = ready_s;
    assign done   = done_s;
    assign result = result_r;
    assign cout   = cout_r;
    assign ovf    = ovf_r;
    assign zero   = zero_r;

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Scoreboard bench for bit_serial_alu_ctrl (WIDTH=8). The driver pushes the
// expected result/flags and done cycle per accepted operation; a monitor pops
// and compares whenever done is seen.
module tb_bit_serial_alu_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
`ifdef ALU_CTRL_ABORT_EN
    logic         abort;
`endif
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic         zero;

    bit_serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
`ifdef ALU_CTRL_ABORT_EN
        .abort  (abort),
`endif
        .op     (op),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf),
        .zero   (zero)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         o;
        logic         z;
        int           cyc;
    } exp_t;

    exp_t         q[$];
    exp_t         mon_e;
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [W-1:0] prev_res = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
            end else begin
                mon_e = q.pop_front();
                chk("result", 32'(result), 32'(mon_e.res));
                chk("cout", 32'(cout), 32'(mon_e.c));
                chk("ovf", 32'(ovf), 32'(mon_e.o));
                chk("zero", 32'(zero), 32'(mon_e.z));
                chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
                chk("ready_in_done", 32'(ready), 32'd0);
            end
        end
    end

    // mode: 0 normal, 1 junk start pulses, 2 reset mid-RUN, 3 abort mid-RUN
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] er, input logic ec, input logic eo,
                         input logic ez, input int mode);
        int   t;
        int   k;
        bit   got;
        exp_t e;
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (ready) got = 1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=0 required=1");
        end
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        t     = cyc;
        start = 1'b0;
        if (mode < 2) begin
            e.res = er; e.c = ec; e.o = eo; e.z = ez; e.cyc = t + W;
            q.push_back(e);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            k = cyc - t;
            if (k == 4) chk("hold_during_run", 32'(result), 32'(prev_res));
            if (mode == 1) begin
                if (k == 2 || k == 7) begin
                    start = 1'b1; op = 3'b100; a = 8'hFF; b = 8'hFF;
                end
                if (k == 3 || k == 8) start = 1'b0;
            end
            if (mode == 2) begin
                if (k == 4) rst_n = 1'b0;
                if (k == 5) begin
                    chk("rst_ready", 32'(ready), 32'd1);
                    chk("rst_done", 32'(done), 32'd0);
                    chk("rst_result", 32'(result), 32'd0);
                    chk("rst_flags", {29'd0, cout, ovf, zero}, 32'd0);
                end
                if (k == 6) rst_n = 1'b1;
            end
`ifdef ALU_CTRL_ABORT_EN
            if (mode == 3) begin
                if (k == 5) abort = 1'b1;
                if (k == 6) begin
                    abort = 1'b0;
                    chk("abort_ready", 32'(ready), 32'd1);
                    chk("abort_result", 32'(result), 32'(prev_res));
                end
            end
`endif
        end
        chk("pending_done", 32'(q.size()), 32'd0);
        q.delete();
        if (mode < 2) prev_res = er;
        if (mode == 2) prev_res = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
`ifdef ALU_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        op = 3'b000;
        a  = '0;
        b  = '0;
        repeat (2) @(negedge clk);
        chk("init_ready", 32'(ready), 32'd1);
        chk("init_done", 32'(done), 32'd0);
        chk("init_result", 32'(result), 32'd0);
        chk("init_flags", {29'd0, cout, ovf, zero}, 32'd0);
        rst_n = 1'b1;
        //    op      a      b      result cout ovf zero mode
        do_op(3'b011, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 0);
        do_op(3'b100, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0, 0);
        do_op(3'b011, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 0);
        do_op(3'b010, 8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b1, 0);
        do_op(3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 0);
        do_op(3'b001, 8'h0F, 8'h30, 8'h3F, 1'b0, 1'b0, 1'b0, 0);
        do_op(3'b111, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 0);
        do_op(3'b100, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0, 0);
        do_op(3'b011, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0, 1);
        do_op(3'b011, 8'h55, 8'h0A, 8'h5F, 1'b0, 1'b0, 1'b0, 2);
        do_op(3'b011, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0, 0);
`ifdef ALU_CTRL_ABORT_EN
        do_op(3'b011, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 3);
        do_op(3'b010, 8'h0F, 8'hFF, 8'hF0, 1'b0, 1'b0, 1'b0, 0);
`endif
        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
